// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the default {pc, instr} field widths, the packed fetch-pair width,
// the all-zero "no entry" value and helpers that split a packed pair.
package instr_fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int FETCH_W = PC_W + INSTR_W;

  localparam logic [FETCH_W-1:0] NULL_FETCH = '0;

  // pc occupies the upper half of the pair
  function automatic logic [PC_W-1:0] fetch_pc(input logic [FETCH_W-1:0] pair);
    return pair[FETCH_W-1:INSTR_W];
  endfunction

  function automatic logic [INSTR_W-1:0] fetch_instr(input logic [FETCH_W-1:0] pair);
    return pair[INSTR_W-1:0];
  endfunction

  function automatic logic [FETCH_W-1:0] make_fetch(input logic [PC_W-1:0]    pc,
                                                    input logic [INSTR_W-1:0] instr);
    return {pc, instr};
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry storage for the instruction fetch queue.
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset; validity is
// tracked by the pointers and count in the parent.
//   clk    : clock
//   we     : write enable
//   waddr  : write index
//   wdata  : write data
//   raddr  : read index
//   rdata  : combinational read data
module ifq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// First-word-fall-through queue between the instruction-cache fetch
// controller and decode. Each completed fetch beat is stored as a
// {pc, instr} pair and presented in order at the head.
//   clk          : clock, all state on rising edge
//   rst_n        : synchronous active-low reset
//   in_valid     : completed fetch beat
//   in_pc_instr  : {pc, instr} of the beat
//   flush        : taken jump, discards every entry
//   out_ready    : decode takes the head entry
//   out_valid    : head entry present
//   out_pc       : head pc, zero when empty
//   out_instr    : head instruction, zero when empty
//   stop_fetch   : free slots <= AF_MARGIN
//   count        : occupancy 0..DEPTH
//   full         : count == DEPTH
//   overflow_err : sticky, a beat was dropped while full
module instr_fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 1,
  parameter int PC_W      = instr_fetch_pkg::PC_W,
  parameter int INSTR_W   = instr_fetch_pkg::INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [PC_W+INSTR_W-1:0]    in_pc_instr,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  output logic                       stop_fetch,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow_err
);

  import instr_fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = PC_W + INSTR_W;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          push;
  logic          pop;
  logic          drop;
  logic [FW-1:0] head;

  // Flags come from the occupancy alone so stop_fetch never loops back
  // through in_valid into the fetch controller.
  assign full       = (cnt == CW'(DEPTH));
  assign out_valid  = (cnt != '0);
  assign stop_fetch = (DEPTH - int'(cnt)) <= AF_MARGIN;

  assign pop  = out_valid & out_ready & ~flush;
  // A full queue still accepts a beat when the head leaves in the same cycle.
  assign push = in_valid & ~flush & (~full | pop);
  assign drop = in_valid & ~flush & full & ~pop;

  ifq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (FW),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_pc_instr),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      // overflow_err is a sticky diagnostic and survives a flush
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage is never cleared, so stale data is masked while empty.
  assign out_pc       = out_valid ? head[FW-1:INSTR_W] : '0;
  assign out_instr    = out_valid ? head[INSTR_W-1:0]  : '0;
  assign count        = cnt;
  assign overflow_err = ovf;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue (DEPTH=4, AF_MARGIN=1).
module tb_instr_fetch_queue;
  import instr_fetch_pkg::*;

  localparam int DEPTH     = 4;
  localparam int AF_MARGIN = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [FETCH_W-1:0] in_pc_instr = '0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic              stop_fetch;
  logic [2:0]        count;
  logic              full;
  logic              overflow_err;

  instr_fetch_queue #(
    .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .PC_W(PC_W), .INSTR_W(INSTR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc_instr(in_pc_instr),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .stop_fetch(stop_fetch),
    .count(count), .full(full), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an ordered list of stored pairs plus the sticky flag.
  logic [FETCH_W-1:0] mq[$];
  bit                 movf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    logic [FETCH_W-1:0] h;
    int sz;
    sz = mq.size();
    h  = (sz != 0) ? mq[0] : NULL_FETCH;
    chk("model count",      64'(count),        64'(sz));
    chk("model out_valid",  64'(out_valid),    64'(sz != 0));
    chk("model out_pc",     64'(out_pc),       64'(fetch_pc(h)));
    chk("model out_instr",  64'(out_instr),    64'(fetch_instr(h)));
    chk("model full",       64'(full),         64'(sz == DEPTH));
    chk("model stop_fetch", 64'(stop_fetch),   64'((DEPTH - sz) <= AF_MARGIN));
    chk("model overflow",   64'(overflow_err), 64'(movf));
  endtask

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return ~pc ^ 32'h1357_9BDF;
  endfunction

  // Drive one cycle of inputs, advance the model by the queue's rules, check.
  task automatic step(input bit v, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                      input bit fl, input bit rdy);
    bit was_full;
    bit mpop;
    in_valid    = v;
    in_pc_instr = make_fetch(pc, ins);
    flush       = fl;
    out_ready   = rdy;
    was_full    = (mq.size() == DEPTH);
    mpop        = (mq.size() != 0) && rdy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (mpop) void'(mq.pop_front());
      if (v) begin
        if (!was_full || mpop) mq.push_back(make_fetch(pc, ins));
        else movf = 1'b1;
      end
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_check();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    movf = 1'b0;
  endtask

  typedef struct {
    bit              v;
    logic [PC_W-1:0] pc;
    bit              fl;
    bit              rdy;
    int              ecount;
    logic [PC_W-1:0] epc;
    bit              eovf;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // fill, overflow, push+pop when full, flush with concurrent beat
    tbl[0] = '{1'b1, 32'h00,  1'b0, 1'b0, 1, 32'h00, 1'b0};
    tbl[1] = '{1'b1, 32'h04,  1'b0, 1'b0, 2, 32'h00, 1'b0};
    tbl[2] = '{1'b1, 32'h08,  1'b0, 1'b0, 3, 32'h00, 1'b0};
    tbl[3] = '{1'b1, 32'h0C,  1'b0, 1'b0, 4, 32'h00, 1'b0};
    tbl[4] = '{1'b1, 32'h10,  1'b0, 1'b0, 4, 32'h00, 1'b1};
    tbl[5] = '{1'b1, 32'h10,  1'b0, 1'b1, 4, 32'h04, 1'b1};
    tbl[6] = '{1'b0, 32'h00,  1'b0, 1'b1, 3, 32'h08, 1'b1};
    tbl[7] = '{1'b1, 32'h200, 1'b1, 1'b0, 0, 32'h00, 1'b1};

    do_reset();
    chk("reset count",      64'(count),        64'd0);
    chk("reset out_valid",  64'(out_valid),    64'd0);
    chk("reset out_pc",     64'(out_pc),       64'd0);
    chk("reset out_instr",  64'(out_instr),    64'd0);
    chk("reset full",       64'(full),         64'd0);
    chk("reset stop_fetch", 64'(stop_fetch),   64'd0);
    chk("reset overflow",   64'(overflow_err), 64'd0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].pc, instr_of(tbl[i].pc), tbl[i].fl, tbl[i].rdy);
      chk($sformatf("vec%0d count", i),    64'(count),        64'(tbl[i].ecount));
      chk($sformatf("vec%0d out_pc", i),   64'(out_pc),       64'(tbl[i].epc));
      chk($sformatf("vec%0d valid", i),    64'(out_valid),    64'(tbl[i].ecount != 0));
      chk($sformatf("vec%0d overflow", i), 64'(overflow_err), 64'(tbl[i].eovf));
      chk($sformatf("vec%0d stop", i),     64'(stop_fetch),   64'(tbl[i].ecount >= 3));
    end

    // Pointer wrap: each beat is head one cycle after its push and is
    // consumed while the next beat enters.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 32'h100 + 32'(4 * k), instr_of(32'h100 + 32'(4 * k)), 1'b0, k > 0);
      chk($sformatf("wrap%0d out_pc", k), 64'(out_pc), 64'(32'h100 + 32'(4 * k)));
      chk($sformatf("wrap%0d count", k),  64'(count),  64'd1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("wrap drained count", 64'(count), 64'd0);

    // Reset while holding two entries, then a fresh beat.
    step(1'b1, 32'h20, instr_of(32'h20), 1'b0, 1'b0);
    step(1'b1, 32'h24, instr_of(32'h24), 1'b0, 1'b0);
    chk("pre-reset count", 64'(count), 64'd2);
    do_reset();
    chk("midreset count",    64'(count),        64'd0);
    chk("midreset valid",    64'(out_valid),    64'd0);
    chk("midreset overflow", 64'(overflow_err), 64'd0);
    step(1'b1, 32'h40, instr_of(32'h40), 1'b0, 1'b0);
    chk("post-reset out_pc",    64'(out_pc),    64'h40);
    chk("post-reset out_instr", 64'(out_instr), 64'(instr_of(32'h40)));

    // Empty + out_ready must not underflow.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("empty pop count", 64'(count), 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 23) == 0,
           ($urandom % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
